// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one uart_tx between byte producers
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       active_id,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  // Timeout fires on the edge where the counter would step to BUSY_TIMEOUT-1.
  localparam logic [CW-1:0]  TO_LAST  = CW'(BUSY_TIMEOUT - 2);
  localparam logic [CW-1:0]  GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;

  logic             hi_found;
  logic             lo_found;
  logic [IDW-1:0]   hi_idx;
  logic [IDW-1:0]   lo_idx;
  logic [IDW-1:0]   gnt_idx;
  logic [7:0]       gnt_data;
  logic [N_REQ-1:0] gnt_onehot;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
  always_comb begin
    hi_found   = 1'b0;
    lo_found   = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    gnt_data   = 8'h00;
    gnt_onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        gnt_onehot[i] = 1'b1;
        gnt_data      = req_data[i*8 +: 8];
      end
    end
  end

  // Grant / transmit-tracking state machine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      req_ack     <= '0;
      active_id   <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_send     <= 1'b0;
      req_ack     <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && lo_found) begin
            tx_data   <= gnt_data;
            req_ack   <= gnt_onehot;
            tx_send   <= 1'b1;
            active_id <= gnt_idx;
            ptr       <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            cnt       <= '0;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            state <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a uart_tx busy model
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int BT  = 16;
  localparam int GAP = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [IDW-1:0] active_id;
  logic           arb_busy;
  logic           err_timeout;

  logic force_busy = 1'b0;
  logic dead = 1'b0;
  logic mbusy;
  int   mcnt;

  assign tx_busy = force_busy | mbusy;

  uart_tx_arbiter #(
    .N_REQ(N), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .active_id(active_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // uart_tx stand-in: busy rises the edge after send and lasts 3..10 cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (mbusy) begin
      if (mcnt <= 1) mbusy <= 1'b0;
      mcnt <= mcnt - 1;
    end else if (tx_send && !dead) begin
      mbusy <= 1'b1;
      mcnt  <= $urandom_range(10, 3);
    end
  end

  logic [7:0] req_q[N][$];
  int         exp_id[$];
  logic [7:0] exp_d[$];
  int         model_ptr = 0;

  // Requesters: present queue front, retire it when acked, immediately offer the next byte
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        if (req_ack[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (req_q[i].size() > 0);
      req_data[i*8 +: 8] = (req_q[i].size() > 0) ? req_q[i][0] : 8'h00;
    end
  end

  int   cyc = 0;
  int   last_fall = -1000;
  bit   skip_gap = 1'b1;
  bit   prev_busy = 1'b0;
  int   to_expect = -1;
  int   to_seen = 0;
  logic [7:0] last_data = 8'h00;

  // Monitor: pops the scoreboard on every send and checks timing rules
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (prev_busy && !tx_busy) last_fall = cyc;
      if (req_ack != '0 && !tx_send) chk("ack_without_send", {28'h0, req_ack}, 32'h0);
      if (tx_send) begin
        chk("send_while_busy", {31'h0, tx_busy}, 32'h0);
        chk("arb_busy_at_send", {31'h0, arb_busy}, 32'h1);
        chk("send_has_expectation", {31'h0, exp_id.size() > 0}, 32'h1);
        if (exp_id.size() > 0) begin
          int id;
          logic [7:0] d;
          id = exp_id.pop_front();
          d  = exp_d.pop_front();
          chk("grant_id", {30'h0, active_id}, id);
          chk("grant_data", {24'h0, tx_data}, {24'h0, d});
          chk("grant_ack", {28'h0, req_ack}, 32'h1 << id);
        end
        if (!skip_gap) chk("gap_after_busy_fall", {31'h0, (cyc - last_fall) >= GAP + 1}, 32'h1);
        skip_gap = 1'b0;
        if (dead) to_expect = cyc + BT - 1;
        last_data = tx_data;
      end else begin
        chk("tx_data_hold", {24'h0, tx_data}, {24'h0, last_data});
      end
      if (err_timeout) begin
        chk("timeout_cycle", cyc, to_expect);
        to_seen++;
        to_expect = -1;
      end else if (to_expect >= 0 && cyc > to_expect) begin
        chk("timeout_missing", cyc, to_expect);
        to_expect = -1;
      end
    end else begin
      last_data = 8'h00;
    end
    prev_busy = tx_busy;
  end

  task automatic push(input int i, input logic [7:0] d);
    req_q[i].push_back(d);
  endtask

  // Reference: serve pending bytes round-robin from start, one byte per visit
  task automatic build_exp(input int start);
    int cnt[N];
    int pos[N];
    int p;
    int left;
    p = start;
    left = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = req_q[i].size();
      pos[i] = 0;
      left += cnt[i];
    end
    while (left > 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (p + k) % N;
        if (cnt[i] > 0) begin
          exp_id.push_back(i);
          exp_d.push_back(req_q[i][pos[i]]);
          pos[i]++;
          cnt[i]--;
          left--;
          p = (i + 1) % N;
          break;
        end
      end
    end
    model_ptr = p;
  endtask

  function automatic bit all_done();
    bit e;
    e = (exp_id.size() == 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) e = 1'b0;
    return e && !arb_busy && !tx_busy;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!all_done() && n < budget);
    chk("idle_within_budget", {31'h0, all_done()}, 32'h1);
  endtask

  initial begin
    int n;
    int t0;
    int w;
    bit any;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx_send", {31'h0, tx_send}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_req_ack", {28'h0, req_ack}, 32'h0);
    chk("rst_active_id", {30'h0, active_id}, 32'h0);
    chk("rst_arb_busy", {31'h0, arb_busy}, 32'h0);
    chk("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);

    push(0, 8'hAA);
    build_exp(model_ptr);
    wait_idle(300);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(8'h11 * i));
    build_exp(model_ptr);
    wait_idle(600);

    push(2, 8'h77);
    build_exp(model_ptr);
    wait_idle(300);
    push(0, 8'hC0);
    push(2, 8'hC2);
    build_exp(model_ptr);
    wait_idle(300);

    repeat (25) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(2, 0);
        for (int b = 0; b < n; b++) push(i, 8'($urandom));
        if (n > 0) any = 1'b1;
      end
      if (!any) push($urandom_range(N - 1, 0), 8'($urandom));
      build_exp(model_ptr);
      wait_idle(800);
    end

    dead = 1'b1;
    t0 = to_seen;
    push($urandom_range(N - 1, 0), 8'($urandom));
    build_exp(model_ptr);
    wait_idle(300);
    repeat (2) @(negedge clk);
    chk("timeout_pulses", to_seen, t0 + 1);
    dead = 1'b0;
    push($urandom_range(N - 1, 0), 8'($urandom));
    build_exp(model_ptr);
    wait_idle(300);

    force_busy = 1'b1;
    push(1, 8'h5C);
    build_exp(model_ptr);
    repeat (3) @(negedge clk);
    req_q[3].push_back(8'h3D);
    repeat (5) @(negedge clk);
    req_q[3].delete();
    repeat (12) @(negedge clk);
    chk("held_while_busy", exp_id.size(), 32'h1);
    skip_gap = 1'b1;
    force_busy = 1'b0;
    wait_idle(300);

    push(0, 8'h01);
    build_exp(model_ptr);
    wait_idle(300);
    push(1, 8'hA1);
    push(0, 8'hA0);
    push(3, 8'hA3);
    build_exp(model_ptr);
    w = 0;
    while (!(exp_id.size() == 2 && tx_busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("reached_wait_done", {31'h0, w < 300}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_tx_send", {31'h0, tx_send}, 32'h0);
    chk("midrst_req_ack", {28'h0, req_ack}, 32'h0);
    chk("midrst_arb_busy", {31'h0, arb_busy}, 32'h0);
    chk("midrst_active_id", {30'h0, active_id}, 32'h0);
    chk("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    exp_id.delete();
    exp_d.delete();
    build_exp(0);
    skip_gap = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
